// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if -- consumer-side bus of the UART receiver.
//
// Signals:
//   rx_clear      consumer -> core  acknowledge, clears rx_ready / rx_overrun
//   rx_data[7:0]  core -> consumer  last received byte
//   rx_ready      core -> consumer  level, byte valid in rx_data
//   rx_frame_err  core -> consumer  one-cycle pulse on a bad stop bit
//   rx_overrun    core -> consumer  sticky, byte landed while rx_ready was set
//   rx_busy       core -> consumer  receiver is not idle
//
// Modports: master = receiver core, slave = consumer.
interface uart_rx_core_if;
    logic       rx_clear;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    modport master (
        input  rx_clear,
        output rx_data, rx_ready, rx_frame_err, rx_overrun, rx_busy
    );

    modport slave (
        output rx_clear,
        input  rx_data, rx_ready, rx_frame_err, rx_overrun, rx_busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core -- 8N1 UART receiver with a held-result consumer handshake.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   rxd    raw asynchronous serial line, idle high, LSB first
//   rx_if  consumer bus (master side), see uart_rx_core_if
//
// Parameters:
//   ClkFrequency  system clock in Hz
//   Baud          serial bit rate; DIV = ClkFrequency/Baud clocks per bit
//
// The line is sampled once per bit at mid-bit: the start bit is re-checked
// HALF clocks after the falling edge, and each later sample is DIV clocks
// after the previous one. Reception never waits on the consumer; a new byte
// simply overwrites rx_data and flags rx_overrun if the old one was unread.
module uart_rx_core #(
    parameter int ClkFrequency = 40000000,
    parameter int Baud         = 9600
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rxd,
    uart_rx_core_if.master rx_if
);

    localparam int DIV  = ClkFrequency / Baud;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          rxd_q1, rxd_s;
    logic          tick;
    logic          stop_ok, stop_err;

    logic [7:0]    rx_data_q;
    logic          rx_ready_q, rx_overrun_q, rx_frame_err_q;

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // leaving reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_q1 <= 1'b1;
            rxd_s  <= 1'b1;
        end else begin
            rxd_q1 <= rxd;
            rxd_s  <= rxd_q1;
        end
    end

    // Bit-timing event: the down-counter has expired this cycle.
    assign tick = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = tick ? cnt : cnt - 1'b1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        stop_ok     = 1'b0;
        stop_err    = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_nxt = START;
                    cnt_nxt   = HALF_M1;
                end
            end
            START: begin
                if (tick) begin
                    // Line back high at mid start bit: treat as a glitch.
                    if (rxd_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = DATA;
                        cnt_nxt     = DIV_M1;
                        bit_idx_nxt = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    // LSB arrives first, so shift in from the top.
                    shreg_nxt   = {rxd_s, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    cnt_nxt     = DIV_M1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (rxd_s) begin
                        stop_ok   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stop_err  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // A low line here is a break or a framing fault, not a
                // start bit; wait for the line to return high first.
                if (rxd_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Consumer handshake. A completing byte always wins over rx_clear;
    // rx_clear in the same cycle only wipes the overrun history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q      <= 8'h00;
            rx_ready_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_frame_err_q <= stop_err;
            if (stop_ok) begin
                rx_data_q  <= shreg;
                rx_ready_q <= 1'b1;
                if (rx_if.rx_clear)  rx_overrun_q <= 1'b0;
                else if (rx_ready_q) rx_overrun_q <= 1'b1;
            end else if (rx_if.rx_clear) begin
                rx_ready_q   <= 1'b0;
                rx_overrun_q <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data      = rx_data_q;
    assign rx_if.rx_ready     = rx_ready_q;
    assign rx_if.rx_overrun   = rx_overrun_q;
    assign rx_if.rx_frame_err = rx_frame_err_q;
    assign rx_if.rx_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core -- scoreboard bench for uart_rx_core at DIV=16.
// Stimulus pushes the expected outcome of every frame it puts on the line;
// a negedge monitor pops and compares whenever a byte or framing error
// appears. Handshake flags are checked against a small ready/overrun model.
module tb_uart_rx_core;
    localparam int CLK_HZ = 160;
    localparam int BAUD   = 10;
    localparam int DIV    = CLK_HZ / BAUD;

    logic clk = 1'b0;
    logic rst_n;
    logic rxd;

    uart_rx_core_if rx_if ();

    uart_rx_core #(.ClkFrequency(CLK_HZ), .Baud(BAUD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .rx_if (rx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         t0;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic chk_eq(input string name, input int act, input int exp);
        chk(act == exp, name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        rx_if.rx_clear = 1'b1;
        tick();
        rx_if.rx_clear = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string name);
        for (int i = 0; i < max; i++) begin
            if (!rx_if.rx_busy) break;
            tick();
        end
        chk_eq(name, int'(rx_if.rx_busy), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_data"},    int'(rx_if.rx_data), 0);
        chk_eq({tag, "_ready"},   int'(rx_if.rx_ready), 0);
        chk_eq({tag, "_ferr"},    int'(rx_if.rx_frame_err), 0);
        chk_eq({tag, "_overrun"}, int'(rx_if.rx_overrun), 0);
        chk_eq({tag, "_busy"},    int'(rx_if.rx_busy), 0);
    endtask

    // One 8N1 frame. clr_tick >= 0 raises rx_clear for one clock that many
    // clocks into the stop bit (10 lands on the stop-sample edge).
    task automatic send_frame(input logic [7:0] b, input bit stop_bit,
                              input bit push, input int clr_tick);
        exp_t e;
        rxd = 1'b0;
        if (push) begin
            e.err  = !stop_bit;
            e.data = b;
            e.t0   = cyc;
            sb.push_back(e);
        end
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) tick();
        end
        rxd = stop_bit;
        for (int k = 0; k < DIV; k++) begin
            rx_if.rx_clear = (k == clr_tick);
            tick();
        end
        rx_if.rx_clear = 1'b0;
    endtask

    // Monitor: a byte is presented when rx_ready rises or rx_data changes
    // while rx_ready is held (overwrite).
    logic       prev_rdy  = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_ferr = 1'b0;

    always @(negedge clk) begin : mon
        exp_t e;
        int   lat;
        if (!rst_n) begin
            prev_rdy  = 1'b0;
            prev_ferr = 1'b0;
        end else begin
            if (rx_if.rx_ready && (!prev_rdy || rx_if.rx_data != prev_data)) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_byte", int'(rx_if.rx_data), -1);
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - e.t0;
                    chk_eq("item_is_byte", 0, int'(e.err));
                    chk_eq("rx_data", int'(rx_if.rx_data), int'(e.data));
                    chk(lat >= 153 && lat <= 155, "ready_latency", lat, 154);
                end
            end
            if (rx_if.rx_frame_err) begin
                if (prev_ferr) begin
                    chk(1'b0, "frame_err_width", 2, 1);
                end else if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_frame_err", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk_eq("item_is_frame_err", 1, int'(e.err));
                end
            end
            prev_rdy  = rx_if.rx_ready;
            prev_data = rx_if.rx_data;
            prev_ferr = rx_if.rx_frame_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got 1 expected 0");
        $fatal(1);
    end

    initial begin
        logic [7:0] b, prev_b;
        bit         m_rdy, m_ovr;
        int         gap;

        rst_n          = 1'b0;
        rxd            = 1'b1;
        rx_if.rx_clear = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) tick();

        // Plain frame, latency checked by the monitor.
        send_frame(8'hA5, 1'b1, 1'b1, -1);
        repeat (4) tick();
        chk_eq("a5_ready", int'(rx_if.rx_ready), 1);
        chk_eq("a5_data", int'(rx_if.rx_data), 8'hA5);
        chk_eq("a5_overrun", int'(rx_if.rx_overrun), 0);
        pulse_clear();
        chk_eq("clear_ready", int'(rx_if.rx_ready), 0);

        // 4-clock low glitch on an idle line.
        rxd = 1'b0;
        repeat (4) tick();
        rxd = 1'b1;
        chk_eq("glitch_busy_seen", int'(rx_if.rx_busy), 1);
        wait_idle(10, "glitch_busy_drop");
        chk_eq("glitch_ready", int'(rx_if.rx_ready), 0);
        repeat (20) tick();

        // Bad stop bit, line held low 40 clocks in total.
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        repeat (40 - DIV) tick();
        chk_eq("break_busy", int'(rx_if.rx_busy), 1);
        chk_eq("break_ready", int'(rx_if.rx_ready), 0);
        rxd = 1'b1;
        wait_idle(6, "break_exit");
        repeat (10) tick();
        send_frame(8'h81, 1'b1, 1'b1, -1);
        repeat (4) tick();
        chk_eq("after_break_data", int'(rx_if.rx_data), 8'h81);
        pulse_clear();

        // Back-to-back frames with no clear: overrun.
        send_frame(8'h11, 1'b1, 1'b1, -1);
        send_frame(8'h22, 1'b1, 1'b1, -1);
        repeat (4) tick();
        chk_eq("ovr_data", int'(rx_if.rx_data), 8'h22);
        chk_eq("ovr_ready", int'(rx_if.rx_ready), 1);
        chk_eq("ovr_flag", int'(rx_if.rx_overrun), 1);
        pulse_clear();
        chk_eq("ovr_clr_ready", int'(rx_if.rx_ready), 0);
        chk_eq("ovr_clr_flag", int'(rx_if.rx_overrun), 0);

        // rx_clear coincident with a stop-success: new byte wins.
        send_frame(8'h66, 1'b1, 1'b1, -1);
        send_frame(8'h77, 1'b1, 1'b1, -1);
        chk_eq("pre_coinc_overrun", int'(rx_if.rx_overrun), 1);
        send_frame(8'h55, 1'b1, 1'b1, 10);
        repeat (4) tick();
        chk_eq("coinc_ready", int'(rx_if.rx_ready), 1);
        chk_eq("coinc_data", int'(rx_if.rx_data), 8'h55);
        chk_eq("coinc_overrun", int'(rx_if.rx_overrun), 0);

        // Reset during bit 4 of 0xF0 (bits 0..3 low, 4..7 high).
        rxd = 1'b0;
        repeat (5 * DIV) tick();
        rxd = 1'b1;
        repeat (DIV / 2) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (DIV / 2 + 4 * DIV + 30) tick();
        chk_eq("aborted_no_ready", int'(rx_if.rx_ready), 0);
        send_frame(8'h0F, 1'b1, 1'b1, -1);
        repeat (4) tick();
        chk_eq("post_reset_data", int'(rx_if.rx_data), 8'h0F);
        pulse_clear();

        // Random frames, gaps and clears against a ready/overrun model.
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
        prev_b = 8'h0F;
        for (int n = 0; n < 20; n++) begin
            do b = 8'($urandom_range(0, 255)); while (b == prev_b);
            prev_b = b;
            send_frame(b, 1'b1, 1'b1, -1);
            m_ovr = m_ovr | m_rdy;
            m_rdy = 1'b1;
            chk_eq("rand_ready", int'(rx_if.rx_ready), int'(m_rdy));
            chk_eq("rand_overrun", int'(rx_if.rx_overrun), int'(m_ovr));
            if ($urandom_range(0, 1) == 1) begin
                pulse_clear();
                m_rdy = 1'b0;
                m_ovr = 1'b0;
            end
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            repeat (gap) tick();
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        chk_eq("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
